// File: rtl/kbd_scan_ctrl_pkg.sv
// Shared constants, state encoding and key-decode helpers for kbd_scan_ctrl.
package kbd_scan_pkg;

  // State encoding is kept as plain vector constants for legacy compatibility.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_EXT     = 3'd1;
  localparam state_t ST_BRK     = 3'd2;
  localparam state_t ST_EXT_BRK = 3'd3;
  localparam state_t ST_EMIT    = 3'd4;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Tracked game keys: index into key_state.
  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_SPACE = 2;
  localparam int unsigned KEY_ENTER = 3;

  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic       EXT_LEFT   = 1'b1;
  localparam logic       EXT_RIGHT  = 1'b1;
  localparam logic       EXT_SPACE  = 1'b0;
  localparam logic       EXT_ENTER  = 1'b0;

  // Bytes that carry no key information (BAT result, ACK, resend, errors, E1 pause prefix).
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                  is_ignored = 1'b0;
    endcase
  endfunction

  // One-hot mask of the tracked key matching code/ext, zero for untracked codes.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = '0;
    if (code == CODE_LEFT  && ext == EXT_LEFT)  key_mask[KEY_LEFT]  = 1'b1;
    if (code == CODE_RIGHT && ext == EXT_RIGHT) key_mask[KEY_RIGHT] = 1'b1;
    if (code == CODE_SPACE && ext == EXT_SPACE) key_mask[KEY_SPACE] = 1'b1;
    if (code == CODE_ENTER && ext == EXT_ENTER) key_mask[KEY_ENTER] = 1'b1;
  endfunction

endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// Byte-in / event-out bundle between the PS/2 bit receiver side and kbd_scan_ctrl.
interface kbd_scan_ctrl_if
  import kbd_scan_pkg::*;
;
  logic [7:0]          byte_in;
  logic                byte_new;
  logic                evt_valid;
  logic [7:0]          evt_code;
  logic                evt_ext;
  logic                evt_break;
  logic [NUM_KEYS-1:0] key_state;
  logic                seq_err;

  // Master supplies bytes and consumes events.
  modport master (
    output byte_in, byte_new,
    input  evt_valid, evt_code, evt_ext, evt_break, key_state, seq_err
  );

  // Slave is the scan-code sequencer.
  modport slave (
    input  byte_in, byte_new,
    output evt_valid, evt_code, evt_ext, evt_break, key_state, seq_err
  );
endinterface

// File: rtl/kbd_scan_ctrl_timeout_cnt.sv
// Inter-byte timeout counter: clear has priority over enable; o_expired flags the edge
// on which the count reaches TIMEOUT_CYC.
module kbd_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled, restart on clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is the increment that would take the count to TIMEOUT_CYC.
  assign o_expired = i_en && !i_clr && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code sequencer: strips E0/F0 prefixes, emits one event per key code,
// tracks held game keys and drops partial sequences on inter-byte timeout.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses repeated makes of held tracked keys.
module kbd_scan_ctrl
  import kbd_scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk,
  input  logic            resetN,
  kbd_scan_ctrl_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_d;
  logic [7:0]          r_code;
  logic                r_ext;
  logic                r_brk;
  logic [NUM_KEYS-1:0] r_keys;
  logic                r_seq_err;

  logic                w_latch;
  logic                w_lat_ext;
  logic                w_lat_brk;
  logic                w_err;
  logic                w_expired;
  logic                w_cnt_en;
  logic                w_cnt_clr;
  logic [NUM_KEYS-1:0] w_mask;

  assign w_cnt_en  = (r_state == ST_EXT) || (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  // A new byte always restarts the count, so it wins over a simultaneous expiry.
  assign w_cnt_clr = bus.byte_new || !w_cnt_en;
  assign w_mask    = key_mask(bus.byte_in, w_lat_ext);

  kbd_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .resetN    (resetN),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  // Next-state decode of the prefix sequence and latch request for the final code.
  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    w_lat_ext = 1'b0;
    w_lat_brk = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      // EMIT decodes a coincident byte exactly like IDLE so back-to-back bytes are kept.
      ST_IDLE, ST_EMIT: begin
        w_state_d = ST_IDLE;
        if (bus.byte_new) begin
          if (bus.byte_in == PFX_EXT) begin
            w_state_d = ST_EXT;
          end else if (bus.byte_in == PFX_BRK) begin
            w_state_d = ST_BRK;
          end else if (!is_ignored(bus.byte_in)) begin
            w_latch = 1'b1;
          end
        end
      end
      ST_EXT: begin
        w_lat_ext = 1'b1;
        if (bus.byte_new) begin
          if (bus.byte_in == PFX_BRK) begin
            w_state_d = ST_EXT_BRK;
          end else if (bus.byte_in == PFX_EXT) begin
            w_err = 1'b1;
          end else begin
            w_latch = 1'b1;
          end
        end else if (w_expired) begin
          w_err     = 1'b1;
          w_state_d = ST_IDLE;
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        w_lat_ext = (r_state == ST_EXT_BRK);
        w_lat_brk = 1'b1;
        if (bus.byte_new) begin
          if (bus.byte_in == PFX_EXT || bus.byte_in == PFX_BRK) begin
            w_err     = 1'b1;
            w_state_d = ST_IDLE;
          end else begin
            w_latch = 1'b1;
          end
        end else if (w_expired) begin
          w_err     = 1'b1;
          w_state_d = ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase

    if (w_latch) begin
      w_state_d = ST_EMIT;
`ifdef KBD_TYPEMATIC_FILTER_EN
      // Repeated make of an already-held tracked key is dropped silently.
      if (!w_lat_brk && ((w_mask & r_keys) != '0)) begin
        w_latch   = 1'b0;
        w_state_d = ST_IDLE;
      end
`endif
    end
  end

  // State, event fields, held-key bitmap and error pulse registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_code    <= '0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_keys    <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_seq_err <= w_err;
      if (w_latch) begin
        r_code <= bus.byte_in;
        r_ext  <= w_lat_ext;
        r_brk  <= w_lat_brk;
        if (w_lat_brk) begin
          r_keys <= r_keys & ~w_mask;
        end else begin
          r_keys <= r_keys | w_mask;
        end
      end
    end
  end

  assign bus.evt_valid = (r_state == ST_EMIT);
  assign bus.evt_code  = r_code;
  assign bus.evt_ext   = r_ext;
  assign bus.evt_break = r_brk;
  assign bus.key_state = r_keys;
  assign bus.seq_err   = r_seq_err;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with TIMEOUT_CYC=100.
module tb_kbd_scan_ctrl;

  logic clk;
  logic resetN;
  int   total;
  int   bad;
  int   ev_cnt;
  int   err_cnt;
  int   snap_ev;
  int   snap_err;
  logic seen;

  kbd_scan_ctrl_if bus ();

  kbd_scan_ctrl #(
    .TIMEOUT_CYC (100)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for event/no-event checks.
  always @(posedge clk) begin
    if (bus.evt_valid === 1'b1) ev_cnt = ev_cnt + 1;
    if (bus.seq_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns on the falling edge after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in  = b;
    bus.byte_new = 1'b1;
    @(negedge clk);
    bus.byte_new = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_evt(input string tag, input logic [7:0] code, input logic ext,
                           input logic brk, input logic [3:0] keys);
    check({tag, ".valid"}, 32'(bus.evt_valid), 32'd1);
    check({tag, ".code"},  32'(bus.evt_code),  32'(code));
    check({tag, ".ext"},   32'(bus.evt_ext),   32'(ext));
    check({tag, ".brk"},   32'(bus.evt_break), 32'(brk));
    check({tag, ".keys"},  32'(bus.key_state), 32'(keys));
  endtask

  initial begin
    total = 0; bad = 0; ev_cnt = 0; err_cnt = 0;
    resetN = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_new = 1'b0;
    idle(3);
    check("rst.valid", 32'(bus.evt_valid), 32'd0);
    check("rst.code",  32'(bus.evt_code),  32'd0);
    check("rst.keys",  32'(bus.key_state), 32'd0);
    check("rst.err",   32'(bus.seq_err),   32'd0);
    resetN = 1'b1;
    idle(2);

    // 1: plain make
    send(8'h1C);
    check_evt("t1", 8'h1C, 1'b0, 1'b0, 4'b0000);
    idle(1);
    check("t1.pulse_one_cycle", 32'(bus.evt_valid), 32'd0);
    check("t1.hold_code", 32'(bus.evt_code), 32'h1C);

    // 2: extended make and break of left
    send(8'hE0);
    check("t2.no_evt_prefix", 32'(bus.evt_valid), 32'd0);
    send(8'h6B);
    check_evt("t2.make", 8'h6B, 1'b1, 1'b0, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_evt("t2.brk", 8'h6B, 1'b1, 1'b1, 4'b0000);

    // 3: typematic space
    idle(2);
    snap_ev = ev_cnt;
    send(8'h29); idle(1);
    send(8'h29); idle(1);
    send(8'h29); idle(2);
`ifdef KBD_TYPEMATIC_FILTER_EN
    check("t3.events", 32'(ev_cnt - snap_ev), 32'd1);
`else
    check("t3.events", 32'(ev_cnt - snap_ev), 32'd3);
`endif
    check("t3.keys", 32'(bus.key_state), 32'b0100);
    send(8'hF0); send(8'h29);
    check_evt("t3.brk", 8'h29, 1'b0, 1'b1, 4'b0000);

    // 4: timeout after E0
    idle(2);
    snap_ev = ev_cnt;
    send(8'hE0);
    seen = 1'b0;
    if (bus.seq_err === 1'b1) seen = 1'b1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (bus.seq_err === 1'b1) seen = 1'b1;
    end
    check("t4.no_early_err", 32'(seen), 32'd0);
    @(negedge clk);
    check("t4.err_at_100", 32'(bus.seq_err), 32'd1);
    @(negedge clk);
    check("t4.err_pulse", 32'(bus.seq_err), 32'd0);
    check("t4.no_evt", 32'(ev_cnt - snap_ev), 32'd0);
    send(8'h5A);
    check_evt("t4.enter", 8'h5A, 1'b0, 1'b0, 4'b1000);
    send(8'hF0); send(8'h5A);
    check_evt("t4.enter_brk", 8'h5A, 1'b0, 1'b1, 4'b0000);

    // 5: illegal prefixes and ignored bytes
    idle(2);
    snap_ev = ev_cnt;
    snap_err = err_cnt;
    send(8'hF0); send(8'hF0);
    check("t5.brkbrk_err", 32'(bus.seq_err), 32'd1);
    send(8'hFA); send(8'hAA);
    idle(2);
    check("t5.no_evt", 32'(ev_cnt - snap_ev), 32'd0);
    check("t5.err_count", 32'(err_cnt - snap_err), 32'd1);
    send(8'hE0); send(8'hE0);
    check("t5.extext_err", 32'(bus.seq_err), 32'd1);
    send(8'h74);
    check_evt("t5.right", 8'h74, 1'b1, 1'b0, 4'b0010);
    idle(2);
    check("t5.err_count2", 32'(err_cnt - snap_err), 32'd2);

    // 6: reset mid-sequence
    send(8'hE0); send(8'h6B);
    check("t6.keys_before", 32'(bus.key_state), 32'b0011);
    send(8'hE0); send(8'hF0);
    resetN = 1'b0;
    idle(2);
    check("t6.rst.valid", 32'(bus.evt_valid), 32'd0);
    check("t6.rst.code",  32'(bus.evt_code),  32'd0);
    check("t6.rst.ext",   32'(bus.evt_ext),   32'd0);
    check("t6.rst.brk",   32'(bus.evt_break), 32'd0);
    check("t6.rst.keys",  32'(bus.key_state), 32'd0);
    check("t6.rst.err",   32'(bus.seq_err),   32'd0);
    resetN = 1'b1;
    idle(1);
    send(8'h74);
    check_evt("t6.after", 8'h74, 1'b0, 1'b0, 4'b0000);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
Sequences the byte stream from the PS/2 bit receiver (`dout`/`dout_new`) into complete scan-code events.
- Strips E0 (extended) and F0 (break) prefixes.
- Drops partial sequences after an inter-byte timeout.
- Keeps a held-key bitmap for the game keys (left, right, space, enter), which the game logic reads directly.

Parameters:
- TIMEOUT_CYC, 1_000_000, clk cycles without a new byte (mid-sequence) before the partial sequence is discarded (20 ms at 50 MHz).
- CNT_W, $clog2(TIMEOUT_CYC+1), width of the timeout counter.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- byte_in  in  8  received byte (bit receiver `dout`)
- byte_new  in  1  one-cycle strobe, byte_in valid (bit receiver `dout_new`)
- evt_valid  out  1  one-cycle pulse, complete event on evt_*
- evt_code  out  8  final scan code of the event
- evt_ext  out  1  event had E0 prefix
- evt_break  out  1  event had F0 prefix (key release)
- key_state  out  4  held keys: [0] left (E0 6B), [1] right (E0 74), [2] space (29), [3] enter (5A)
- seq_err  out  1  one-cycle pulse on timeout or illegal prefix

Behaviour:
- Reset: asynchronous on resetN, active-low; clock is clk. Reset forces state IDLE, timeout counter 0, and every output 0. Reset mid-sequence discards the sequence and clears key_state.
- States: IDLE, EXT, BRK, EXT_BRK, EMIT. All transitions occur only on cycles with byte_new=1, except the timeout and the EMIT exit.
- IDLE:
  - E0 → EXT; F0 → BRK.
  - Ignored bytes (00, AA, E1, FA, FE, FF) → stay IDLE, no event.
  - Any other byte → latch code with ext=0, brk=0 → EMIT.
- EXT: F0 → EXT_BRK; E0 → seq_err, stay EXT (counter restarts); other → latch ext=1, brk=0 → EMIT.
- BRK: E0 or F0 → seq_err → IDLE; other → latch ext=0, brk=1 → EMIT.
- EXT_BRK: E0 or F0 → seq_err → IDLE; other → latch ext=1, brk=1 → EMIT.
- EMIT:
  - evt_valid=1 for exactly this cycle; next state is IDLE.
  - A byte_new arriving in EMIT is decoded with IDLE's rules, so no byte is lost.
- Latency and registering:
  - evt_code, evt_ext, evt_break and key_state all update on the clock edge that enters EMIT. The pulse therefore appears in the cycle after the final byte_new.
  - evt_* hold their values between events.
- key_state update: a make of a tracked key sets its bit; a break clears it. Untracked codes produce an event but no state change.
- Timeout:
  - The counter is held at 0 in IDLE/EMIT and cleared on every byte_new.
  - It increments each cycle in EXT, BRK and EXT_BRK.
  - On reaching TIMEOUT_CYC: seq_err pulse, → IDLE, no event.
  - If a byte_new and expiry fall in the same cycle, the byte wins and the counter restarts.
- seq_err is registered and never asserted in the same cycle as evt_valid.

Optional Feature:
- Macro: KBD_TYPEMATIC_FILTER_EN.
- Defined: a make event for a tracked key whose key_state bit is already 1 is suppressed. The FSM goes straight to IDLE, with no EMIT and evt_* unchanged. Untracked keys and breaks are never filtered.
- Undefined: every typematic repeat produces an event.

Decomposition:
- Package kbd_scan_pkg:
  - state enum;
  - constants PFX_EXT=8'hE0, PFX_BRK=8'hF0;
  - ignored-byte list;
  - tracked key codes and their ext flags;
  - key index localparams (KEY_LEFT=0 … KEY_ENTER=3).
- Sub-module kbd_timeout_cnt: clear / enable / expired, CNT_W wide. It is instantiated once.

Test Plan:
1. byte 1C → evt_valid 1 cycle after strobe; code=1C, ext=0, brk=0; key_state=0000.
2. E0 6B → ext=1, code=6B, brk=0, key_state=0001. Then E0 F0 6B → ext=1, brk=1, key_state=0000.
3. 29 ×3 (typematic) → 3 events and key_state=0100 without the macro; 1 event with KBD_TYPEMATIC_FILTER_EN. Then F0 29 → brk=1, key_state=0000.
4. TIMEOUT_CYC=100; E0 followed by 100 idle cycles → seq_err pulse exactly 100 cycles after the strobe, no event. Next 5A → code=5A, ext=0, key_state=1000.
5. F0 F0 → seq_err, no event. FA, AA → no event, no error. E0 E0 74 → one seq_err, then ext=1, code=74, key_state=0010.
6. E0 F0, then resetN low for 2 cycles mid-sequence, with key_state=0011 beforehand → all outputs 0, state IDLE. Next 74 → ext=0, code=74, key_state unchanged at 0000.
